// File: rtl/moore_seq_detector_p_if.sv
// Serial-input bus for the parametrised Moore pattern detector.
//  master: drives en, x, cfg_load, cfg_pattern, cfg_overlap, cnt_clr
//          and observes match, state, match_count, cnt_sat
//  slave : the detector itself
interface moore_seq_detector_p_if #(
    parameter int unsigned LEN   = 4,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned SW = $clog2(LEN + 1);

    logic             en;
    logic             x;
    logic             cfg_load;
    logic [LEN-1:0]   cfg_pattern;
    logic             cfg_overlap;
    logic             cnt_clr;
    logic             match;
    logic [SW-1:0]    state;
    logic [CNT_W-1:0] match_count;
    logic             cnt_sat;

    modport master (
        output en, x, cfg_load, cfg_pattern, cfg_overlap, cnt_clr,
        input  match, state, match_count, cnt_sat
    );

    modport slave (
        input  en, x, cfg_load, cfg_pattern, cfg_overlap, cnt_clr,
        output match, state, match_count, cnt_sat
    );
endinterface

// File: rtl/moore_seq_detector_p.sv
// Parametrised Moore serial-pattern detector with programmable pattern,
// selectable overlap mode, registered match output and saturating counter.
//  clk, rst_n : rising-edge clock, asynchronous active-low reset
//  bus        : slave side of moore_seq_detector_p_if
//               inputs  en, x, cfg_load, cfg_pattern, cfg_overlap, cnt_clr
//               outputs match, state, match_count, cnt_sat (all registered)
module moore_seq_detector_p #(
    parameter int unsigned    LEN             = 4,
    parameter logic [LEN-1:0] DEFAULT_PATTERN = LEN'(4'b1101),
    parameter bit             DEFAULT_OVERLAP = 1'b1,
    parameter int unsigned    CNT_W           = 8,
    parameter int unsigned    SW              = $clog2(LEN + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    moore_seq_detector_p_if.slave  bus
);

    // State k = number of leading pattern bits currently matched.
    typedef enum logic [SW-1:0] {
        S0      = SW'(0),
        S_MATCH = SW'(LEN)
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [LEN-1:0]   pattern_q, pattern_d;
    logic             overlap_q, overlap_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             hit;

    // KMP failure rule: longest pattern prefix that is a suffix of
    // (first k pattern bits, b). Pattern bit i lives at pat[LEN-1-i].
    function automatic logic [SW-1:0] kmp_next(
        input logic [SW-1:0]  k,
        input logic           b,
        input logic [LEN-1:0] pat
    );
        logic [SW-1:0] best;
        logic          ok;
        logic          sb;
        int            m;
        best = '0;
        for (int j = 1; j <= int'(LEN); j++) begin
            if (j <= int'(k) + 1) begin
                ok = 1'b1;
                for (int i = 0; i < int'(LEN); i++) begin
                    if (i < j) begin
                        m = int'(k) + 1 - j + i;
                        if (m >= int'(k)) begin
                            sb = b;
                        end else begin
                            sb = pat[int'(LEN) - 1 - m];
                        end
                        if (sb != pat[int'(LEN) - 1 - i]) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = SW'(j);
                end
            end
        end
        return best;
    endfunction

    // State and configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S0;
            pattern_q <= DEFAULT_PATTERN;
            overlap_q <= DEFAULT_OVERLAP;
            match_q   <= 1'b0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            overlap_q <= overlap_d;
            match_q   <= match_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
        end
    end

    // Next-state, configuration and counter logic.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        overlap_d = overlap_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        hit       = 1'b0;

        if (bus.cfg_load) begin
            pattern_d = bus.cfg_pattern;
            overlap_d = bus.cfg_overlap;
        end

        // Illegal encodings and reconfiguration both restart at S0; x is ignored.
        if (state_q > S_MATCH || bus.cfg_load) begin
            state_d = S0;
        end else if (bus.en) begin
            if (state_q == S_MATCH && !overlap_q) begin
                state_d = (bus.x == pattern_q[LEN-1]) ? state_e'(SW'(1)) : S0;
            end else begin
                state_d = state_e'(kmp_next(state_q, bus.x, pattern_q));
            end
            hit = (state_d == S_MATCH);
        end

        // Clear has priority over a simultaneous increment.
        if (bus.cnt_clr) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (hit) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (cnt_q >= CNT_MAX - CNT_W'(1)) begin
                sat_d = 1'b1;
            end
        end

        match_d = (state_d == S_MATCH);
    end

    assign bus.match       = match_q;
    assign bus.state       = state_q;
    assign bus.match_count = cnt_q;
    assign bus.cnt_sat     = sat_q;

endmodule

// File: tb/tb_moore_seq_detector_p.sv
// Directed, table-driven bench for moore_seq_detector_p.
//  dut1: LEN=4, CNT_W=8 (main function, overlap, en stall, cfg, clear, reset)
//  dut2: LEN=4, CNT_W=2 (counter saturation and clear-vs-increment)
module tb_moore_seq_detector_p;

    logic clk;
    logic rst_n;

    moore_seq_detector_p_if #(.LEN(4), .CNT_W(8)) bus1 ();
    moore_seq_detector_p_if #(.LEN(4), .CNT_W(2)) bus2 ();

    moore_seq_detector_p #(.LEN(4), .CNT_W(8)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    moore_seq_detector_p #(.LEN(4), .CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       en;
        logic       x;
        logic       ld;
        logic [3:0] pat;
        logic       ovl;
        logic       clr;
        logic [2:0] st;
        logic       m;
        logic [7:0] cnt;
    } vec_t;

    vec_t vq[$];
    int   n_err;
    int   n_chk;

    function automatic vec_t v(int en, int x, int ld, int pat, int ovl, int clr,
                               int st, int m, int cnt);
        vec_t r;
        r.en  = 1'(en);
        r.x   = 1'(x);
        r.ld  = 1'(ld);
        r.pat = 4'(pat);
        r.ovl = 1'(ovl);
        r.clr = 1'(clr);
        r.st  = 3'(st);
        r.m   = 1'(m);
        r.cnt = 8'(cnt);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive1(input vec_t t);
        bus1.en          = t.en;
        bus1.x           = t.x;
        bus1.cfg_load    = t.ld;
        bus1.cfg_pattern = t.pat;
        bus1.cfg_overlap = t.ovl;
        bus1.cnt_clr     = t.clr;
    endtask

    int   e_cnt;
    logic e_sat;
    int   e_st;
    logic e_m;
    logic [3:0] seq;

    initial begin
        n_err = 0;
        n_chk = 0;
        rst_n = 1'b0;
        drive1(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
        bus2.en          = 1'b0;
        bus2.x           = 1'b0;
        bus2.cfg_load    = 1'b0;
        bus2.cfg_pattern = 4'b0000;
        bus2.cfg_overlap = 1'b0;
        bus2.cnt_clr     = 1'b0;

        //      en x ld pat     ovl clr  st m cnt
        // Default 1101, overlap: stream 1101101
        vq.push_back(v(1, 1, 0, 0,       0, 0,  1, 0, 0));
        vq.push_back(v(1, 1, 0, 0,       0, 0,  2, 0, 0));
        vq.push_back(v(1, 0, 0, 0,       0, 0,  3, 0, 0));
        vq.push_back(v(1, 1, 0, 0,       0, 0,  4, 1, 1));
        vq.push_back(v(1, 1, 0, 0,       0, 0,  2, 0, 1));
        vq.push_back(v(1, 0, 0, 0,       0, 0,  3, 0, 1));
        vq.push_back(v(1, 1, 0, 0,       0, 0,  4, 1, 2));
        // Non-overlap 1101: stream 1101101 (x ignored during load)
        vq.push_back(v(1, 1, 1, 4'b1101, 0, 0,  0, 0, 2));
        vq.push_back(v(1, 1, 0, 0,       0, 0,  1, 0, 2));
        vq.push_back(v(1, 1, 0, 0,       0, 0,  2, 0, 2));
        vq.push_back(v(1, 0, 0, 0,       0, 0,  3, 0, 2));
        vq.push_back(v(1, 1, 0, 0,       0, 0,  4, 1, 3));
        vq.push_back(v(1, 1, 0, 0,       0, 0,  1, 0, 3));
        vq.push_back(v(1, 0, 0, 0,       0, 0,  0, 0, 3));
        vq.push_back(v(1, 1, 0, 0,       0, 0,  1, 0, 3));
        // 1111 overlap: six ones, match held three cycles
        vq.push_back(v(1, 1, 1, 4'b1111, 1, 0,  0, 0, 3));
        vq.push_back(v(1, 1, 0, 0,       0, 0,  1, 0, 3));
        vq.push_back(v(1, 1, 0, 0,       0, 0,  2, 0, 3));
        vq.push_back(v(1, 1, 0, 0,       0, 0,  3, 0, 3));
        vq.push_back(v(1, 1, 0, 0,       0, 0,  4, 1, 4));
        vq.push_back(v(1, 1, 0, 0,       0, 0,  4, 1, 5));
        vq.push_back(v(1, 1, 0, 0,       0, 0,  4, 1, 6));
        // 1101 overlap with en stalls in S2 and in MATCH
        vq.push_back(v(1, 1, 1, 4'b1101, 1, 0,  0, 0, 6));
        vq.push_back(v(1, 1, 0, 0,       0, 0,  1, 0, 6));
        vq.push_back(v(1, 1, 0, 0,       0, 0,  2, 0, 6));
        vq.push_back(v(0, 0, 0, 0,       0, 0,  2, 0, 6));
        vq.push_back(v(1, 0, 0, 0,       0, 0,  3, 0, 6));
        vq.push_back(v(1, 1, 0, 0,       0, 0,  4, 1, 7));
        vq.push_back(v(0, 1, 0, 0,       0, 0,  4, 1, 7));
        vq.push_back(v(1, 0, 0, 0,       0, 0,  0, 0, 7));
        // cnt_clr leaves FSM running; clear beats a same-cycle match
        vq.push_back(v(1, 1, 0, 0,       0, 1,  1, 0, 0));
        vq.push_back(v(1, 1, 0, 0,       0, 0,  2, 0, 0));
        vq.push_back(v(1, 0, 0, 0,       0, 0,  3, 0, 0));
        vq.push_back(v(1, 1, 0, 0,       0, 1,  4, 1, 0));
        // cfg_load with cnt_clr, then pattern 0110 overlap: 0110 11 -> S3
        vq.push_back(v(1, 1, 1, 4'b0110, 1, 1,  0, 0, 0));
        vq.push_back(v(1, 0, 0, 0,       0, 0,  1, 0, 0));
        vq.push_back(v(1, 1, 0, 0,       0, 0,  2, 0, 0));
        vq.push_back(v(1, 1, 0, 0,       0, 0,  3, 0, 0));
        vq.push_back(v(1, 0, 0, 0,       0, 0,  4, 1, 1));
        vq.push_back(v(1, 1, 0, 0,       0, 0,  2, 0, 1));
        vq.push_back(v(1, 1, 0, 0,       0, 0,  3, 0, 1));

        // Reset values while rst_n is held low
        #12;
        chk("rst state",     int'(bus1.state),       0);
        chk("rst match",     int'(bus1.match),       0);
        chk("rst count",     int'(bus1.match_count), 0);
        chk("rst sat",       int'(bus1.cnt_sat),     0);
        chk("rst2 count",    int'(bus2.match_count), 0);
        chk("rst2 sat",      int'(bus2.cnt_sat),     0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            drive1(vq[i]);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d state", i), int'(bus1.state),       int'(vq[i].st));
            chk($sformatf("vec%0d match", i), int'(bus1.match),       int'(vq[i].m));
            chk($sformatf("vec%0d count", i), int'(bus1.match_count), int'(vq[i].cnt));
        end
        @(negedge clk);
        drive1(v(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // CNT_W=2: five matches on 1101101101101101, clear on the fifth
        e_cnt = 0;
        e_sat = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            bus2.en      = 1'b1;
            bus2.x       = (i % 3 != 0);
            bus2.cnt_clr = (i == 16);
            if (i <= 2)          e_st = i;
            else if (i % 3 == 0) e_st = 3;
            else if (i % 3 == 1) e_st = 4;
            else                 e_st = 2;
            e_m = (e_st == 4);
            if (i == 16) begin
                e_cnt = 0;
                e_sat = 1'b0;
            end else if (e_m) begin
                if (e_cnt < 3) e_cnt++;
                if (e_cnt == 3) e_sat = 1'b1;
            end
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d state", i), int'(bus2.state),       e_st);
            chk($sformatf("sat%0d match", i), int'(bus2.match),       int'(e_m));
            chk($sformatf("sat%0d count", i), int'(bus2.match_count), e_cnt);
            chk($sformatf("sat%0d flag",  i), int'(bus2.cnt_sat),     int'(e_sat));
        end
        @(negedge clk);
        bus2.en      = 1'b0;
        bus2.cnt_clr = 1'b0;

        // Async reset mid-stream: dut1 in S3 with pattern 0110, dut2 in MATCH
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst state",  int'(bus1.state),       0);
        chk("arst match",  int'(bus1.match),       0);
        chk("arst count",  int'(bus1.match_count), 0);
        chk("arst2 state", int'(bus2.state),       0);
        chk("arst2 match", int'(bus2.match),       0);

        // After release the default 1101 must be back in force
        seq = 4'b1101;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            drive1(v(1, int'(seq[3 - i]), 0, 0, 0, 0, 0, 0, 0));
            @(posedge clk);
            #1;
            chk($sformatf("post%0d state", i), int'(bus1.state), i + 1);
            chk($sformatf("post%0d match", i), int'(bus1.match), (i == 3) ? 1 : 0);
        end
        chk("post count", int'(bus1.match_count), 1);

        @(negedge clk);
        drive1(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
